// File: rtl/axis_pkg.sv
// Shared types for the aligning stream combiner: FSM state encoding and
// the width of the forced-frame counter.
package axis_pkg;

  localparam int PCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    FIRE_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/axis_align_combiner_if.sv
// Bundle of the per-channel input streams and the combined output stream.
// slave = the combiner side, master = traffic source/sink side.
interface axis_align_combiner_if #(
  parameter int DW = 24,
  parameter int N  = 2
);
  logic [DW-1:0] s_axis_tdata  [N];
  logic          s_axis_tvalid [N];
  logic          s_axis_tready [N];
  logic [DW-1:0] m_axis_tdata  [N];
  logic [N-1:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );
endinterface

// File: rtl/axis_fifo.sv
// Per-channel FIFO with combinational read port; empty_nxt predicts the
// emptiness after this cycle's push/pop so the combiner FSM can track it.
module axis_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic          empty_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_nxt;
  logic          wr_en, rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (wr_en && !rd_en)      cnt_nxt = cnt + 1'b1;
    else if (rd_en && !wr_en) cnt_nxt = cnt - 1'b1;
  end

  assign empty_nxt = (cnt_nxt == '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/axis_align_combiner.sv
// Aligns N per-channel streams into one frame per output beat; with TIMEOUT>0
// a stalled partial frame is forced out with missing lanes zeroed.
//   state     | meaning
//   IDLE      | all active FIFOs empty, en_mask is latched each cycle
//   COLLECT   | some active FIFO holds data, waiting for the rest
//   FIRE_WAIT | timeout expired, waiting for the output register to free
module axis_align_combiner
  import axis_pkg::*;
#(
  parameter int DW      = 24,
  parameter int N       = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      en_mask,
  axis_align_combiner_if.slave bus,
  output logic [PCNT_W-1:0] partial_cnt
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [N-1:0]  active_q, act_mask;
  logic [N-1:0]  empty_w, empty_nxt_w, full_w, push, pop;
  logic [N-1:0]  fifo_ne, fifo_ne_nxt;
  logic [DW-1:0] rdata [N];
  logic [TW-1:0] tcnt;
  logic          out_free, all_ne, any_ne, timeout_hit;
  logic          full_fire, partial_fire, fire;

  // Outside IDLE the mask is frozen so a frame never changes shape mid-collection
  assign act_mask    = (state == IDLE) ? en_mask : active_q;
  assign fifo_ne     = ~empty_w;
  assign fifo_ne_nxt = ~empty_nxt_w;

  for (genvar g = 0; g < N; g++) begin : g_ch
    axis_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .pop       (pop[g]),
      .wdata     (bus.s_axis_tdata[g]),
      .rdata     (rdata[g]),
      .empty     (empty_w[g]),
      .full      (full_w[g]),
      .empty_nxt (empty_nxt_w[g])
    );
    assign bus.s_axis_tready[g] = !rst && (!act_mask[g] || !full_w[g]);
    assign push[g] = act_mask[g] && bus.s_axis_tvalid[g] && !full_w[g];
    assign pop[g]  = fire && act_mask[g] && fifo_ne[g];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Disabled channels never hold data, so "any FIFO non-empty next" is exact
  always_comb begin
    state_nxt = state;
    if (timeout_hit && !fire && any_ne) state_nxt = FIRE_WAIT;
    else if (|fifo_ne_nxt)              state_nxt = COLLECT;
    else                                state_nxt = IDLE;
  end

  always_comb begin
    out_free     = !bus.m_axis_tvalid || bus.m_axis_tready;
    all_ne       = (act_mask != '0) && ((fifo_ne & act_mask) == act_mask);
    any_ne       = |(fifo_ne & act_mask);
    timeout_hit  = 1'b0;
    if (TIMEOUT > 0)
      timeout_hit = (state == FIRE_WAIT) ||
                    ((state == COLLECT) && (tcnt == TW'(TIMEOUT - 1)));
    full_fire    = all_ne && out_free;
    partial_fire = !all_ne && any_ne && timeout_hit && out_free;
    fire         = full_fire || partial_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      tcnt     <= '0;
    end else begin
      if (state == IDLE) active_q <= en_mask;
      if (fire || state == IDLE || state_nxt == IDLE)
        tcnt <= '0;
      else if (TIMEOUT > 0 && state == COLLECT && !timeout_hit)
        tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tuser  <= '0;
      for (int i = 0; i < N; i++) bus.m_axis_tdata[i] <= '0;
      partial_cnt <= '0;
    end else begin
      if (fire) begin
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tuser  <= pop;
        for (int i = 0; i < N; i++)
          bus.m_axis_tdata[i] <= pop[i] ? rdata[i] : '0;
      end else if (bus.m_axis_tready) begin
        bus.m_axis_tvalid <= 1'b0;
      end
      if (partial_fire && partial_cnt != '1)
        partial_cnt <= partial_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_align_combiner.sv
// Directed bench: dut_a runs strict lockstep, dut_b forces partial frames
// after 8 cycles; both see identical stimulus.
module tb_axis_align_combiner;
  localparam int DW = 24;
  localparam int N  = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  tb_en;
  logic [DW-1:0] tb_tdata [N];
  logic          tb_tvalid [N];
  logic          tb_mready;
  logic [15:0]   pcnt_a, pcnt_b;
  int            n_vec = 0;
  int            n_err = 0;

  axis_align_combiner_if #(.DW(DW), .N(N)) if_a ();
  axis_align_combiner_if #(.DW(DW), .N(N)) if_b ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign if_a.s_axis_tdata[g]  = tb_tdata[g];
    assign if_a.s_axis_tvalid[g] = tb_tvalid[g];
    assign if_b.s_axis_tdata[g]  = tb_tdata[g];
    assign if_b.s_axis_tvalid[g] = tb_tvalid[g];
  end
  assign if_a.m_axis_tready = tb_mready;
  assign if_b.m_axis_tready = tb_mready;

  axis_align_combiner #(.DW(DW), .N(N), .DEPTH(DEPTH), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .en_mask(tb_en), .bus(if_a), .partial_cnt(pcnt_a));
  axis_align_combiner #(.DW(DW), .N(N), .DEPTH(DEPTH), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .en_mask(tb_en), .bus(if_b), .partial_cnt(pcnt_b));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      tb_tvalid[i] = 1'b0;
      tb_tdata[i]  = '0;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] en);
    rst = 1'b1;
    tb_en = en;
    tb_mready = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tb_en = 2'b11;
    tb_mready = 1'b1;
    idle_inputs();
    step();
    step();
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (if_a.s_axis_tready[i] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_tready[%0d]: got %0b expected 0", i, if_a.s_axis_tready[i]);
      end
    end
    n_vec++;
    if (if_a.m_axis_tvalid !== 1'b0 || if_b.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_tvalid: got %0b/%0b expected 0/0", if_a.m_axis_tvalid, if_b.m_axis_tvalid);
    end
    n_vec++;
    if (if_a.m_axis_tuser !== 2'b00 || if_a.m_axis_tdata[0] !== '0 || if_a.m_axis_tdata[1] !== '0) begin
      n_err++;
      $display("FAIL rst_out: got tuser %b tdata %h %h expected 0 0 0", if_a.m_axis_tuser,
               if_a.m_axis_tdata[0], if_a.m_axis_tdata[1]);
    end
    n_vec++;
    if (pcnt_a !== 16'h0 || pcnt_b !== 16'h0) begin
      n_err++;
      $display("FAIL rst_pcnt: got %h/%h expected 0/0", pcnt_a, pcnt_b);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (if_a.s_axis_tready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_release_tready: got %0b expected 1", if_a.s_axis_tready[0]);
    end
  endtask

  task automatic test_lockstep();
    do_reset(2'b11);
    tb_tdata[0] = 24'h000001; tb_tvalid[0] = 1'b1;
    tb_tdata[1] = 24'h000002; tb_tvalid[1] = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (if_a.s_axis_tready[i] !== 1'b1) begin
        n_err++;
        $display("FAIL ls_tready[%0d]: got %0b expected 1", i, if_a.s_axis_tready[i]);
      end
    end
    step();
    idle_inputs();
    n_vec++;
    if (if_a.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ls_latency1: got tvalid %0b expected 0", if_a.m_axis_tvalid);
    end
    step();
    n_vec++;
    if (if_a.m_axis_tvalid !== 1'b1 || if_a.m_axis_tdata[0] !== 24'h1 ||
        if_a.m_axis_tdata[1] !== 24'h2 || if_a.m_axis_tuser !== 2'b11) begin
      n_err++;
      $display("FAIL ls_frame: got v%0b %h %h u%b expected v1 000001 000002 u11", if_a.m_axis_tvalid,
               if_a.m_axis_tdata[0], if_a.m_axis_tdata[1], if_a.m_axis_tuser);
    end
    n_vec++;
    if (if_b.m_axis_tvalid !== 1'b1 || if_b.m_axis_tuser !== 2'b11) begin
      n_err++;
      $display("FAIL ls_frame_b: got v%0b u%b expected v1 u11", if_b.m_axis_tvalid, if_b.m_axis_tuser);
    end
    step();
    n_vec++;
    if (if_a.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ls_drain: got tvalid %0b expected 0", if_a.m_axis_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    do_reset(2'b11);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        tb_tdata[0] = 24'h000010 + DW'(c); tb_tvalid[0] = 1'b1;
        tb_tdata[1] = 24'h000020 + DW'(c); tb_tvalid[1] = 1'b1;
      end else begin
        idle_inputs();
      end
      step();
      exp_v = (c >= 1) && (c <= 4);
      n_vec++;
      if (if_a.m_axis_tvalid !== exp_v) begin
        n_err++;
        $display("FAIL b2b_tvalid c%0d: got %0b expected %0b", c, if_a.m_axis_tvalid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (if_a.m_axis_tdata[0] !== 24'h000010 + DW'(c - 1) ||
            if_a.m_axis_tdata[1] !== 24'h000020 + DW'(c - 1)) begin
          n_err++;
          $display("FAIL b2b_data c%0d: got %h %h expected %h %h", c, if_a.m_axis_tdata[0],
                   if_a.m_axis_tdata[1], 24'h000010 + DW'(c - 1), 24'h000020 + DW'(c - 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got0 [$];
    logic [DW-1:0] got1 [$];
    do_reset(2'b11);
    tb_mready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tb_tdata[0] = 24'h000100 + DW'(i); tb_tvalid[0] = 1'b1;
      n_vec++;
      if (if_a.s_axis_tready[0] !== 1'b1) begin
        n_err++;
        $display("FAIL bp_fill_tready w%0d: got %0b expected 1", i, if_a.s_axis_tready[0]);
      end
      step();
    end
    tb_tdata[0] = 24'h000104;
    n_vec++;
    if (if_a.s_axis_tready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full_tready: got %0b expected 0", if_a.s_axis_tready[0]);
    end
    step();
    n_vec++;
    if (if_a.s_axis_tready[0] !== 1'b0 || if_a.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_hold: got tready %0b tvalid %0b expected 0 0", if_a.s_axis_tready[0],
               if_a.m_axis_tvalid);
    end
    tb_tdata[1] = 24'h000200; tb_tvalid[1] = 1'b1;
    step();
    tb_tvalid[1] = 1'b0;
    n_vec++;
    if (if_a.s_axis_tready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_prepop_tready: got %0b expected 0", if_a.s_axis_tready[0]);
    end
    step();
    n_vec++;
    if (if_a.s_axis_tready[0] !== 1'b1 || if_a.m_axis_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_after_fire: got tready %0b tvalid %0b expected 1 1", if_a.s_axis_tready[0],
               if_a.m_axis_tvalid);
    end
    step();
    tb_tvalid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (if_a.m_axis_tvalid !== 1'b1 || if_a.m_axis_tdata[0] !== 24'h000100 ||
          if_a.m_axis_tdata[1] !== 24'h000200) begin
        n_err++;
        $display("FAIL bp_stable k%0d: got v%0b %h %h expected v1 000100 000200", k,
                 if_a.m_axis_tvalid, if_a.m_axis_tdata[0], if_a.m_axis_tdata[1]);
      end
      step();
    end
    tb_mready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        tb_tdata[1] = 24'h000201 + DW'(c); tb_tvalid[1] = 1'b1;
      end else begin
        tb_tvalid[1] = 1'b0;
      end
      if (if_a.m_axis_tvalid && tb_mready) begin
        got0.push_back(if_a.m_axis_tdata[0]);
        got1.push_back(if_a.m_axis_tdata[1]);
      end
      step();
    end
    n_vec++;
    if (got0.size() != 5) begin
      n_err++;
      $display("FAIL bp_frame_count: got %0d expected 5", got0.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < got0.size()) begin
        n_vec++;
        if (got0[k] !== 24'h000100 + DW'(k) || got1[k] !== 24'h000200 + DW'(k)) begin
          n_err++;
          $display("FAIL bp_frame%0d: got %h %h expected %h %h", k, got0[k], got1[k],
                   24'h000100 + DW'(k), 24'h000200 + DW'(k));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int early;
    do_reset(2'b11);
    tb_tdata[1] = 24'hABCDEF; tb_tvalid[1] = 1'b1;
    step();
    idle_inputs();
    early = 0;
    for (int c = 1; c <= 8; c++) begin
      if (if_b.m_axis_tvalid !== 1'b0) early++;
      step();
    end
    n_vec++;
    if (early != 0) begin
      n_err++;
      $display("FAIL to_early: got %0d cycles with tvalid expected 0", early);
    end
    n_vec++;
    if (if_b.m_axis_tvalid !== 1'b1 || if_b.m_axis_tdata[0] !== 24'h0 ||
        if_b.m_axis_tdata[1] !== 24'hABCDEF || if_b.m_axis_tuser !== 2'b10) begin
      n_err++;
      $display("FAIL to_frame: got v%0b %h %h u%b expected v1 000000 abcdef u10", if_b.m_axis_tvalid,
               if_b.m_axis_tdata[0], if_b.m_axis_tdata[1], if_b.m_axis_tuser);
    end
    n_vec++;
    if (pcnt_b !== 16'd1) begin
      n_err++;
      $display("FAIL to_pcnt: got %0d expected 1", pcnt_b);
    end
    n_vec++;
    if (if_a.m_axis_tvalid !== 1'b0 || pcnt_a !== 16'd0) begin
      n_err++;
      $display("FAIL to_strict: got tvalid %0b pcnt %0d expected 0 0", if_a.m_axis_tvalid, pcnt_a);
    end
    step();
    n_vec++;
    if (if_b.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL to_drain: got tvalid %0b expected 0", if_b.m_axis_tvalid);
    end
  endtask

  task automatic test_mask();
    logic exp_v;
    do_reset(2'b01);
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        tb_tdata[0] = 24'h000300 + DW'(c); tb_tvalid[0] = 1'b1;
      end else begin
        tb_tvalid[0] = 1'b0;
      end
      tb_tdata[1]  = 24'hDEAD00 + DW'(c);
      tb_tvalid[1] = (c % 2) == 1;
      n_vec++;
      if (if_a.s_axis_tready[1] !== 1'b1) begin
        n_err++;
        $display("FAIL mask_tready1 c%0d: got %0b expected 1", c, if_a.s_axis_tready[1]);
      end
      step();
      exp_v = (c >= 1) && (c <= 3);
      n_vec++;
      if (if_a.m_axis_tvalid !== exp_v) begin
        n_err++;
        $display("FAIL mask_tvalid c%0d: got %0b expected %0b", c, if_a.m_axis_tvalid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (if_a.m_axis_tdata[0] !== 24'h000300 + DW'(c - 1) || if_a.m_axis_tdata[1] !== 24'h0 ||
            if_a.m_axis_tuser !== 2'b01) begin
          n_err++;
          $display("FAIL mask_frame c%0d: got %h %h u%b expected %h 000000 u01", c,
                   if_a.m_axis_tdata[0], if_a.m_axis_tdata[1], if_a.m_axis_tuser,
                   24'h000300 + DW'(c - 1));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_fire_wait();
    do_reset(2'b11);
    tb_mready = 1'b0;
    tb_tdata[0] = 24'h000400; tb_tvalid[0] = 1'b1;
    tb_tdata[1] = 24'h000500; tb_tvalid[1] = 1'b1;
    step();
    idle_inputs();
    step();
    tb_tdata[0] = 24'h000401; tb_tvalid[0] = 1'b1;
    step();
    idle_inputs();
    repeat (11) step();
    n_vec++;
    if (if_b.m_axis_tvalid !== 1'b1 || if_b.m_axis_tdata[0] !== 24'h000400 ||
        if_b.m_axis_tdata[1] !== 24'h000500 || pcnt_b !== 16'd0) begin
      n_err++;
      $display("FAIL fw_held: got v%0b %h %h pcnt %0d expected v1 000400 000500 0",
               if_b.m_axis_tvalid, if_b.m_axis_tdata[0], if_b.m_axis_tdata[1], pcnt_b);
    end
    tb_mready = 1'b1;
    step();
    n_vec++;
    if (if_b.m_axis_tvalid !== 1'b1 || if_b.m_axis_tdata[0] !== 24'h000401 ||
        if_b.m_axis_tdata[1] !== 24'h0 || if_b.m_axis_tuser !== 2'b01) begin
      n_err++;
      $display("FAIL fw_fire: got v%0b %h %h u%b expected v1 000401 000000 u01", if_b.m_axis_tvalid,
               if_b.m_axis_tdata[0], if_b.m_axis_tdata[1], if_b.m_axis_tuser);
    end
    n_vec++;
    if (pcnt_b !== 16'd1) begin
      n_err++;
      $display("FAIL fw_pcnt: got %0d expected 1", pcnt_b);
    end
    step();
    n_vec++;
    if (if_b.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL fw_drain: got tvalid %0b expected 0", if_b.m_axis_tvalid);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    do_reset(2'b11);
    tb_tdata[0] = 24'h00005A; tb_tvalid[0] = 1'b1;
    step();
    idle_inputs();
    repeat (10) step();
    n_vec++;
    if (pcnt_b !== 16'd1) begin
      n_err++;
      $display("FAIL rm_pre_pcnt: got %0d expected 1", pcnt_b);
    end
    tb_mready = 1'b0;
    tb_tdata[0] = 24'h000061; tb_tvalid[0] = 1'b1;
    tb_tdata[1] = 24'h000071; tb_tvalid[1] = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tb_tdata[0] = 24'h000600 + DW'(i); tb_tvalid[0] = 1'b1;
      step();
    end
    idle_inputs();
    n_vec++;
    if (if_b.m_axis_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL rm_pre_tvalid: got %0b expected 1", if_b.m_axis_tvalid);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if (if_a.m_axis_tvalid !== 1'b0 || if_b.m_axis_tvalid !== 1'b0 || pcnt_b !== 16'd0) begin
      n_err++;
      $display("FAIL rm_reset: got tvalid %0b/%0b pcnt %0d expected 0/0 0", if_a.m_axis_tvalid,
               if_b.m_axis_tvalid, pcnt_b);
    end
    n_vec++;
    if (if_b.s_axis_tready[0] !== 1'b0 || if_b.s_axis_tready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rm_tready: got %0b %0b expected 0 0", if_b.s_axis_tready[0], if_b.s_axis_tready[1]);
    end
    rst = 1'b0;
    tb_mready = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (if_a.m_axis_tvalid !== 1'b0 || if_b.m_axis_tvalid !== 1'b0) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_err++;
      $display("FAIL rm_stale: got %0d cycles with tvalid expected 0", stale);
    end
    tb_tdata[0] = 24'h000700; tb_tvalid[0] = 1'b1;
    tb_tdata[1] = 24'h000701; tb_tvalid[1] = 1'b1;
    step();
    idle_inputs();
    step();
    n_vec++;
    if (if_a.m_axis_tvalid !== 1'b1 || if_a.m_axis_tdata[0] !== 24'h000700 ||
        if_a.m_axis_tdata[1] !== 24'h000701) begin
      n_err++;
      $display("FAIL rm_fresh: got v%0b %h %h expected v1 000700 000701", if_a.m_axis_tvalid,
               if_a.m_axis_tdata[0], if_a.m_axis_tdata[1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    tb_en = 2'b11;
    tb_mready = 1'b0;
    idle_inputs();
    test_reset();
    test_lockstep();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_mask();
    test_fire_wait();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
